// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per CALC cycle,
// 32 iterations for *W forms and XLEN otherwise. The result is registered
// and held in DONE until the pipeline acknowledges it.
// Optional feature macro: MULDIV_DIV_BYPASS_EN (divide by zero and signed
// overflow finish after a single cycle instead of the full iteration count).
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the start edge
//   CALC  | iterating; counter counts down to 1, final fixup at count==1
//   DONE  | result valid and held until ack (or flush)

module ex_muldiv #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_muldiv_start_i,
   input  logic [2:0]      ex_muldiv_op_i,
   input  logic            ex_muldiv_inst_word_i,
   input  logic [XLEN-1:0] ex_muldiv_rs1_data_i,
   input  logic [XLEN-1:0] ex_muldiv_rs2_data_i,
   input  logic            ex_muldiv_flush_i,
   input  logic            ex_muldiv_ack_i,
   output logic            ex_muldiv_busy_o,
   output logic            ex_muldiv_valid_o,
   output logic [XLEN-1:0] ex_muldiv_res_data_o
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              state_q, state_nx;
   logic [CW-1:0]       cnt_q;
   logic [2:0]          op_q;
   logic                word_q, negq_q, negr_q, zero_q, ovf_q, valid_q;
   logic [XLEN-1:0]     dvd_q, a_q, b_q, res_q;
   logic [2*XLEN-1:0]   acc_q;

   logic                sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf, bypass;
   logic [XLEN-1:0]     ext_a, ext_b, mag_a, mag_b;
   logic [2*XLEN-1:0]   acc_nx, addend;
   logic [XLEN-1:0]     a_nx;
   logic [XLEN:0]       rem_sh;
   logic [XLEN+1:0]     diff;

   // Final fixup: sign correction, special divide values, half and word select.
   function automatic logic [XLEN-1:0] fixup(
      input logic [2:0]        op,
      input logic              word, neg_q, neg_r, zero, ovf,
      input logic [XLEN-1:0]   dvd,
      input logic [2*XLEN-1:0] acc_v,
      input logic [XLEN-1:0]   quo);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   q, r, v;
      prod = neg_q ? -acc_v : acc_v;
      q    = neg_q ? -quo : quo;
      r    = neg_r ? -acc_v[XLEN-1:0] : acc_v[XLEN-1:0];
      if (zero) begin
         q = '1;
         r = dvd;
      end else if (ovf) begin
         q = dvd;
         r = '0;
      end
      if (!op[2])
         v = (op[1:0] != 2'd0 && !word) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      else
         v = op[1] ? r : q;
      if (word)
         v = {{(XLEN-32){v[31]}}, v[31:0]};
      return v;
   endfunction

   // Operand conditioning at issue: word extension, signs, magnitudes, special cases.
   always_comb begin
      sgn_a = (ex_muldiv_op_i == 3'd1) || (ex_muldiv_op_i == 3'd2) ||
              (ex_muldiv_op_i == 3'd4) || (ex_muldiv_op_i == 3'd6);
      sgn_b = (ex_muldiv_op_i == 3'd1) || (ex_muldiv_op_i == 3'd4) ||
              (ex_muldiv_op_i == 3'd6);
      ext_a = ex_muldiv_rs1_data_i;
      ext_b = ex_muldiv_rs2_data_i;
      if (ex_muldiv_inst_word_i) begin
         ext_a = {{(XLEN-32){sgn_a & ex_muldiv_rs1_data_i[31]}}, ex_muldiv_rs1_data_i[31:0]};
         ext_b = {{(XLEN-32){sgn_b & ex_muldiv_rs2_data_i[31]}}, ex_muldiv_rs2_data_i[31:0]};
      end
      neg_a    = sgn_a & ext_a[XLEN-1];
      neg_b    = sgn_b & ext_b[XLEN-1];
      mag_a    = neg_a ? -ext_a : ext_a;
      mag_b    = neg_b ? -ext_b : ext_b;
      div_zero = ex_muldiv_op_i[2] & (ext_b == '0);
      div_ovf  = ex_muldiv_op_i[2] & ~ex_muldiv_op_i[0] & (&ext_b) &
                 (ex_muldiv_inst_word_i ? (ext_a == {{(XLEN-31){1'b1}}, 31'b0})
                                        : (ext_a == {1'b1, {(XLEN-1){1'b0}}}));
`ifdef MULDIV_DIV_BYPASS_EN
      bypass   = div_zero | div_ovf;
`else
      bypass   = 1'b0;
`endif
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      acc_nx = acc_q;
      a_nx   = a_q;
      addend = '0;
      rem_sh = '0;
      diff   = '0;
      if (op_q[2]) begin
         rem_sh = {acc_q[XLEN-1:0], a_q[XLEN-1]};
         diff   = {1'b0, rem_sh} - {2'b00, b_q};
         acc_nx = diff[XLEN+1] ? {{(XLEN-1){1'b0}}, rem_sh}
                               : {{(XLEN-1){1'b0}}, diff[XLEN:0]};
         a_nx   = {a_q[XLEN-2:0], ~diff[XLEN+1]};
      end else begin
         if (a_q[XLEN-1])
            addend = {{XLEN{1'b0}}, b_q};
         acc_nx = {acc_q[2*XLEN-2:0], 1'b0} + addend;
         a_nx   = {a_q[XLEN-2:0], 1'b0};
      end
   end

   // Next-state and stall request; flush overrides ack and start.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:  if (ex_muldiv_start_i) state_nx = S_CALC;
         S_CALC:  if (cnt_q == CW'(1)) state_nx = S_DONE;
         S_DONE:  if (ex_muldiv_ack_i) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (ex_muldiv_flush_i)
         state_nx = S_IDLE;
      ex_muldiv_busy_o = (ex_muldiv_start_i && state_q == S_IDLE) ||
                         (state_q == S_CALC) ||
                         (state_q == S_DONE && !ex_muldiv_ack_i);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nx;
   end

   // Datapath: capture on issue, iterate in CALC, register the fixed-up result.
   // A bypassed special divide loads a count of 1 so the result lands one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         op_q    <= '0;
         word_q  <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dvd_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_nx == S_DONE);
         if (state_q == S_IDLE && ex_muldiv_start_i && !ex_muldiv_flush_i) begin
            op_q   <= ex_muldiv_op_i;
            word_q <= ex_muldiv_inst_word_i;
            negq_q <= neg_a ^ neg_b;
            negr_q <= neg_a;
            zero_q <= div_zero;
            ovf_q  <= div_ovf;
            dvd_q  <= ext_a;
            acc_q  <= '0;
            if (ex_muldiv_op_i[2]) begin
               a_q <= ex_muldiv_inst_word_i ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
               b_q <= mag_b;
            end else begin
               a_q <= ex_muldiv_inst_word_i ? {mag_b[31:0], {(XLEN-32){1'b0}}} : mag_b;
               b_q <= mag_a;
            end
            if (bypass)
               cnt_q <= CW'(1);
            else
               cnt_q <= ex_muldiv_inst_word_i ? CW'(32) : CW'(XLEN);
         end else if (state_q == S_CALC && !ex_muldiv_flush_i) begin
            acc_q <= acc_nx;
            a_q   <= a_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               res_q <= fixup(op_q, word_q, negq_q, negr_q, zero_q, ovf_q,
                              dvd_q, acc_nx, a_nx);
         end
      end
   end

   assign ex_muldiv_valid_o    = valid_q;
   assign ex_muldiv_res_data_o = res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vectors, expected results queued at issue
// and compared by an independent monitor on each acknowledged result.

module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, word, flush, ack;
   logic [2:0]  op;
   logic [63:0] rs1, rs2;
   logic        busy, valid;
   logic [63:0] res;

`ifdef MULDIV_DIV_BYPASS_EN
   localparam int SPEC64 = 1;
   localparam int SPEC32 = 1;
`else
   localparam int SPEC64 = 64;
   localparam int SPEC32 = 32;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] exp_q[$];
   string       name_q[$];
   logic [63:0] mon_exp;
   string       mon_name;

   ex_muldiv #(.XLEN(64)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .ex_muldiv_start_i    (start),
      .ex_muldiv_op_i       (op),
      .ex_muldiv_inst_word_i(word),
      .ex_muldiv_rs1_data_i (rs1),
      .ex_muldiv_rs2_data_i (rs2),
      .ex_muldiv_flush_i    (flush),
      .ex_muldiv_ack_i      (ack),
      .ex_muldiv_busy_o     (busy),
      .ex_muldiv_valid_o    (valid),
      .ex_muldiv_res_data_o (res)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Monitor: every acknowledged result is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && valid && ack) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got %h expected none", res);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check(mon_name, res, mon_exp);
         end
      end
   end

   task automatic run_op(input string nm, input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                         input int lat_exp, input int hold);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      op = o; word = w; rs1 = a; rs2 = b; start = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      #1 busy_ok = busy;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!valid && lat < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1 lat++;
      end
      check({nm, "_latency"}, 64'(lat), 64'(lat_exp));
      check({nm, "_busy"}, {63'b0, busy_ok}, 64'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({nm, "_hold_res"}, res, e);
         check({nm, "_hold_busy"}, {63'b0, busy & valid}, 64'd1);
      end
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      check({nm, "_idle_after_ack"}, {62'b0, valid, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      rst = 1'b1; start = 1'b0; word = 1'b0; flush = 1'b0; ack = 1'b0;
      op = 3'd0; rs1 = '0; rs2 = '0;
      repeat (3) @(posedge clk);
      #1 check("reset_outputs", {res[61:0], valid, busy}, 64'd0);
      @(negedge clk) rst = 1'b0;

      run_op("mul_7_m3",   3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0);
      run_op("mulhu_max",  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0);
      run_op("mulh_m1_1",  3'd1, 1'b0, '1, 64'd1, '1, 64, 0);
      run_op("mulhsu_2_u", 3'd2, 1'b0, 64'd2, '1, 64'd1, 64, 0);
      run_op("mulw_ovf",   3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0);
      run_op("mulhw_as_mulw", 3'd3, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0);
      run_op("divw_ovf",   3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, SPEC32, 0);
      run_op("remw_m7_2",  3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 32, 0);
      run_op("div_m20_3",  3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 64, 0);
      run_op("rem_m20_3",  3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0);
      run_op("divu_5_0",   3'd5, 1'b0, 64'd5, 64'd0, '1, SPEC64, 0);
      run_op("remu_5_0",   3'd7, 1'b0, 64'd5, 64'd0, 64'd5, SPEC64, 0);
      run_op("rem_ovf",    3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, SPEC64, 0);

      // Flush during CALC: no result, then a fresh divide.
      @(negedge clk);
      op = 3'd4; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_idle", {62'b0, valid, busy}, 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1 if (valid) seen = 1'b1;
      end
      check("flush_no_valid", {63'b0, seen}, 64'd0);
      run_op("div_100_7", 3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0);

      // Ack held off for 5 cycles in DONE.
      run_op("div_100_7_hold", 3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 64, 5);

      // Reset mid-CALC.
      @(negedge clk);
      op = 3'd0; word = 1'b0; rs1 = 64'd3; rs2 = 64'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("rst_mid_calc", {res[61:0], valid, busy}, 64'd0);
      @(negedge clk) rst = 1'b0;
      seen = 1'b0;
      repeat (70) begin
         @(posedge clk);
         #1 if (valid) seen = 1'b1;
      end
      check("rst_no_valid", {63'b0, seen}, 64'd0);
      run_op("mul_after_rst", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 64, 0);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
